// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
//
// Read-domain consumer of the async FIFO read pointer block. It issues read
// requests (r_en) whenever the FIFO is non-empty and there is room for the
// returning word. Registered RAM read data is caught in a 2-entry buffer, and
// the buffer is presented downstream as a valid/ready stream at one word per
// cycle. A read is never issued while r_empty is high, so the pointer block
// cannot underflow.
//
// Read latency: r_en in cycle N -> rdata captured at end of N+1 -> m_valid in N+2.
//
// Ports
//   rclk     in   1      read-domain clock
//   rrst     in   1      asynchronous active-low reset
//   r_empty  in   1      FIFO empty flag from the read pointer block
//   r_en     out  1      read request (combinational from r_empty, m_ready, state)
//   rdata    in   DATA   RAM read data, valid the cycle after an accepted r_en
//   m_data   out  DATA   stream data (head of buffer)
//   m_valid  out  1      stream valid
//   m_ready  in   1      stream ready from downstream
//   level    out  2      buffered word count 0..2 (excludes the in-flight read)
//
// Optional feature (macro FIFO_RD_PARITY_EN)
//   rpar     in   1      even parity over rdata, same timing as rdata
//   m_perr   out  1      parity error flag of the word on m_data, qualified by m_valid
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
    parameter int DATA = 6,
    parameter int ADDR = 6   // pointer width incl. wrap bit; sizing reference only
) (
    input  logic            rclk,
    input  logic            rrst,
    input  logic            r_empty,
    output logic            r_en,
    input  logic [DATA-1:0] rdata,
`ifdef FIFO_RD_PARITY_EN
    input  logic            rpar,
    output logic            m_perr,
`endif
    output logic [DATA-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [1:0]      level
);

    // A pointer needs at least one address bit plus the wrap bit.
    if (ADDR < 2) begin : g_addr_check
        $error("fifo_rd_stream_adapter: ADDR must be at least 2");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } level_e;

    level_e          level_q, level_d;
    logic            inflight_q, inflight_d;
    logic            m_valid_q, m_valid_d;
    logic [DATA-1:0] slot0_q, slot0_d;
    logic [DATA-1:0] slot1_q, slot1_d;
`ifdef FIFO_RD_PARITY_EN
    logic            perr0_q, perr0_d;
    logic            perr1_q, perr1_d;
    logic            perr_in;
`endif

    logic            pop;
    logic            land;
    logic [1:0]      occ;

    // NOTE: combinational logic uses blocking '=', flops use non-blocking '<='
    //       so every flop samples the pre-edge value of every other flop.
    always_comb begin
        pop  = m_valid_q & m_ready;
        land = inflight_q;
        // Words already committed: buffered plus the read still in flight.
        occ  = 2'(level_q) + {1'b0, inflight_q};
        // A full commitment (2) may still read when the head leaves this cycle.
        r_en = rrst & ~r_empty & ((occ <= 2'd1) | ((occ == 2'd2) & pop));
    end

`ifdef FIFO_RD_PARITY_EN
    assign perr_in = ^{rdata, rpar};
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        //       unassigned, which would otherwise infer a latch.
        level_d    = level_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        inflight_d = r_en;
`ifdef FIFO_RD_PARITY_EN
        perr0_d    = perr0_q;
        perr1_d    = perr1_q;
`endif
        unique case (level_q)
            EMPTY: begin
                if (land) begin
                    level_d = ONE;
                    slot0_d = rdata;
`ifdef FIFO_RD_PARITY_EN
                    perr0_d = perr_in;
`endif
                end
            end
            ONE: begin
                if (land && !pop) begin
                    level_d = TWO;
                    slot1_d = rdata;
`ifdef FIFO_RD_PARITY_EN
                    perr1_d = perr_in;
`endif
                end else if (!land && pop) begin
                    level_d = EMPTY;
                end else if (land && pop) begin
                    slot0_d = rdata;
`ifdef FIFO_RD_PARITY_EN
                    perr0_d = perr_in;
`endif
                end
            end
            TWO: begin
                // The read rule never lets a word land while both slots are full.
                if (pop) begin
                    level_d = ONE;
                    slot0_d = slot1_q;
`ifdef FIFO_RD_PARITY_EN
                    perr0_d = perr1_q;
`endif
                end
            end
            default: level_d = EMPTY;
        endcase
        m_valid_d = (level_d != EMPTY);
    end

    // NOTE: the buffer slots are reset along with the control state so that
    //       m_data reads 0 out of reset and no stale word survives a reset.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            level_q    <= EMPTY;
            inflight_q <= 1'b0;
            m_valid_q  <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
`ifdef FIFO_RD_PARITY_EN
            perr0_q    <= 1'b0;
            perr1_q    <= 1'b0;
`endif
        end else begin
            level_q    <= level_d;
            inflight_q <= inflight_d;
            m_valid_q  <= m_valid_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
`ifdef FIFO_RD_PARITY_EN
            perr0_q    <= perr0_d;
            perr1_q    <= perr1_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = slot0_q;
    assign level   = level_q;
`ifdef FIFO_RD_PARITY_EN
    assign m_perr  = perr0_q & m_valid_q;
`endif

endmodule
